input_manager: RTL and testbench

- Sits directly downstream of the NES controller reader and also drives its start strobe.
- Polls the pad at a fixed rate and debounces the 8 button bits across successive polls.
- Emits one-cycle press pulses for the A, B, Select and Start buttons.
- Holds a single-entry "requested direction" register that the Pac-Man movement logic consumes via a valid/ack handshake.

---
 rtl/input_manager.sv | 177 +++++++++++++++++
 tb/tb_input_manager.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_manager.sv
// NES pad poller: strobes the controller reader at a fixed rate, debounces the eight
// button bits across polls, and turns debounced presses into pulses plus a direction request.
module input_manager_db #(
    parameter int DEBOUNCE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sample,
    output logic stable_q,
    output logic stable_d
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (en) begin
            if (sample == cand_q) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            end else begin
                cand_d = sample;
                cnt_d  = CNT_ONE;
            end
            if (cnt_d == CNT_MAX) stable_d = cand_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q   <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end
endmodule

module input_manager #(
    parameter int POLL_PERIOD = 2778,
    parameter int SETTLE      = 22,
    parameter int DEBOUNCE    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:7] buttons_pressed,
    output logic       start_out,
    output logic [0:7] buttons_stable,
    output logic       a_press,
    output logic       b_press,
    output logic       select_press,
    output logic       start_press,
    output logic [1:0] dir,
    output logic       dir_valid,
    input  logic       dir_ack
);
    localparam int NUM_BTN = 8;
    localparam int PW = $clog2(POLL_PERIOD);
    localparam int SW = $clog2(SETTLE);
    localparam logic [PW-1:0] POLL_LAST   = PW'(POLL_PERIOD - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, SAMPLE} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  poll_cnt_q, poll_cnt_d;
    logic [SW-1:0]  wait_cnt_q, wait_cnt_d;
    logic           start_out_q, start_out_d;
    logic [0:3]     press_q, press_d;
    logic [1:0]     dir_q, dir_d;
    logic           dir_valid_q, dir_valid_d;
    logic [0:7]     stable_q, stable_d, rise;
    logic           ud_cancel, lr_cancel;
    logic           sample_en;

    assign sample_en = (state_q == SAMPLE);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        input_manager_db #(.DEBOUNCE(DEBOUNCE)) u_db (
            .clk     (clk),
            .rst     (rst),
            .en      (sample_en),
            .sample  (buttons_pressed[i]),
            .stable_q(stable_q[i]),
            .stable_d(stable_d[i])
        );
    end

    // wait_cnt runs from the first STROBE cycle so STROBE+WAIT spans SETTLE cycles
    always_comb begin
        state_d    = state_q;
        poll_cnt_d = poll_cnt_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (poll_cnt_q == POLL_LAST) begin
                    poll_cnt_d = '0;
                    wait_cnt_d = '0;
                    state_d    = STROBE;
                end else begin
                    poll_cnt_d = poll_cnt_q + PW'(1);
                end
            end
            STROBE: begin
                wait_cnt_d = wait_cnt_q + SW'(1);
                if (wait_cnt_q == SW'(1)) state_d = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == SETTLE_LAST) state_d = SAMPLE;
                else wait_cnt_d = wait_cnt_q + SW'(1);
            end
            default: begin
                wait_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
        start_out_d = (state_d == STROBE);
    end

    // stable_d differs from stable_q only on the SAMPLE edge, so rises are one-shot
    always_comb begin
        rise        = stable_d & ~stable_q;
        press_d     = rise[0:3];
        ud_cancel   = stable_d[4] & stable_d[5];
        lr_cancel   = stable_d[6] & stable_d[7];
        dir_d       = dir_q;
        dir_valid_d = dir_valid_q;
        if (dir_valid_q && dir_ack) dir_valid_d = 1'b0;
        if (rise[4] && !ud_cancel) begin
            dir_d = 2'b00; dir_valid_d = 1'b1;
        end else if (rise[5] && !ud_cancel) begin
            dir_d = 2'b01; dir_valid_d = 1'b1;
        end else if (rise[6] && !lr_cancel) begin
            dir_d = 2'b10; dir_valid_d = 1'b1;
        end else if (rise[7] && !lr_cancel) begin
            dir_d = 2'b11; dir_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            poll_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            start_out_q <= 1'b0;
            press_q     <= '0;
            dir_q       <= 2'b00;
            dir_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            poll_cnt_q  <= poll_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            start_out_q <= start_out_d;
            press_q     <= press_d;
            dir_q       <= dir_d;
            dir_valid_q <= dir_valid_d;
        end
    end

    assign start_out      = start_out_q;
    assign buttons_stable = stable_q;
    assign a_press        = press_q[0];
    assign b_press        = press_q[1];
    assign select_press   = press_q[2];
    assign start_press    = press_q[3];
    assign dir            = dir_q;
    assign dir_valid      = dir_valid_q;
endmodule

// File: tb/tb_input_manager.sv
// Bench for input_manager: hand-computed poll table, reset-in-WAIT sequence, and
// randomized polls checked against a history-based debounce/direction model.
module tb_input_manager;
    localparam int PP = 32;
    localparam int ST = 22;
    localparam int DB = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:7] buttons_pressed;
    logic       start_out;
    logic [0:7] buttons_stable;
    logic       a_press, b_press, select_press, start_press;
    logic [1:0] dir;
    logic       dir_valid;
    logic       dir_ack;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    input_manager #(.POLL_PERIOD(PP), .SETTLE(ST), .DEBOUNCE(DB)) dut (
        .clk            (clk),
        .rst            (rst),
        .buttons_pressed(buttons_pressed),
        .start_out      (start_out),
        .buttons_stable (buttons_stable),
        .a_press        (a_press),
        .b_press        (b_press),
        .select_press   (select_press),
        .start_press    (start_press),
        .dir            (dir),
        .dir_valid      (dir_valid),
        .dir_ack        (dir_ack)
    );

    typedef struct {
        logic [0:7] b;
        logic       ack;
        logic [0:7] stable;
        logic [0:3] press;
        logic [1:0] dir;
        logic       valid;
    } vec_t;

    vec_t tbl[28];
    vec_t dummy;

    // model: debounced level = value shared by the last DB samples, else unchanged
    logic [0:7] hist[$];
    logic [0:7] m_stable;
    logic [0:3] m_press;
    logic [1:0] m_dir;
    logic       m_valid;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [0:3] presses();
        return {a_press, b_press, select_press, start_press};
    endfunction

    function automatic void model_reset();
        hist.delete();
        m_stable = '0;
        m_press  = '0;
        m_dir    = 2'b00;
        m_valid  = 1'b0;
    endfunction

    function automatic void model_sample(logic [0:7] b, logic ack);
        logic [0:7] nxt, rise;
        logic [0:3] cand;
        bit same;
        hist.push_back(b);
        if (hist.size() > DB) void'(hist.pop_front());
        nxt = m_stable;
        if (hist.size() == DB) begin
            for (int i = 0; i < 8; i++) begin
                same = 1;
                foreach (hist[j]) if (hist[j][i] != hist[0][i]) same = 0;
                if (same) nxt[i] = hist[0][i];
            end
        end
        rise     = nxt & ~m_stable;
        m_press  = rise[0:3];
        cand     = rise[4:7];
        if (nxt[4] && nxt[5]) begin cand[0] = 1'b0; cand[1] = 1'b0; end
        if (nxt[6] && nxt[7]) begin cand[2] = 1'b0; cand[3] = 1'b0; end
        m_stable = nxt;
        if (m_valid && ack) m_valid = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (cand[k]) begin m_dir = 2'(k); m_valid = 1'b1; end
        end
    endfunction

    task automatic wait_rise(input int exp, input string nm);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!start_out && k < 200);
        check(nm, 32'(k), 32'(exp));
    endtask

    // entered on the negedge where start_out has just risen (step 0)
    task automatic poll(input logic [0:7] b, input logic ack_mid, input logic ack_s,
                        input logic use_tbl, input vec_t e);
        logic [0:7] xs; logic [0:3] xp; logic [1:0] xd; logic xv;
        buttons_pressed = b;
        @(negedge clk); check("strobe_2nd_cycle", 32'(start_out), 32'd1);
        @(negedge clk); check("strobe_ends", 32'(start_out), 32'd0);
        for (int k = 3; k <= 22; k++) begin
            @(negedge clk);
            if (k == 10) dir_ack = ack_mid;
            if (k == 11) begin
                dir_ack = 1'b0;
                if (ack_mid) begin
                    m_valid = 1'b0;
                    check("ack_alone_valid", 32'(dir_valid), 32'(m_valid));
                end
            end
        end
        check("stable_before_sample", 32'(buttons_stable), 32'(m_stable));
        check("no_press_before_sample", 32'(presses()), 32'd0);
        dir_ack = ack_s;
        model_sample(b, ack_s);
        if (use_tbl) begin xs = e.stable; xp = e.press; xd = e.dir; xv = e.valid; end
        else begin xs = m_stable; xp = m_press; xd = m_dir; xv = m_valid; end
        @(negedge clk);
        dir_ack = 1'b0;
        check("stable", 32'(buttons_stable), 32'(xs));
        check("press", 32'(presses()), 32'(xp));
        check("dir", 32'(dir), 32'(xd));
        check("dir_valid", 32'(dir_valid), 32'(xv));
        @(negedge clk); check("press_one_cycle", 32'(presses()), 32'd0);
        wait_rise(PP + 2 + (ST - 2) + 1 - 24, "poll_spacing");
    endtask

    initial begin
        logic [0:7] rb;
        logic am, as;
        rst = 1'b1;
        buttons_pressed = '0;
        dir_ack = 1'b0;
        dummy = '{8'h00, 1'b0, 8'h00, 4'h0, 2'b00, 1'b0};
        model_reset();

        tbl[0]  = '{8'b0000_1000, 1'b0, 8'b0000_0000, 4'b0000, 2'b00, 1'b0};
        tbl[1]  = '{8'b0000_1000, 1'b0, 8'b0000_1000, 4'b0000, 2'b00, 1'b1};
        tbl[2]  = '{8'b0000_1000, 1'b1, 8'b0000_1000, 4'b0000, 2'b00, 1'b0};
        tbl[3]  = '{8'b0000_1000, 1'b0, 8'b0000_1000, 4'b0000, 2'b00, 1'b0};
        tbl[4]  = '{8'b0001_0000, 1'b0, 8'b0000_1000, 4'b0000, 2'b00, 1'b0};
        tbl[5]  = '{8'b0000_0000, 1'b0, 8'b0000_0000, 4'b0000, 2'b00, 1'b0};
        tbl[6]  = '{8'b0001_0000, 1'b0, 8'b0000_0000, 4'b0000, 2'b00, 1'b0};
        tbl[7]  = '{8'b0001_0000, 1'b0, 8'b0001_0000, 4'b0001, 2'b00, 1'b0};
        tbl[8]  = '{8'b0000_0000, 1'b0, 8'b0001_0000, 4'b0000, 2'b00, 1'b0};
        tbl[9]  = '{8'b0000_0000, 1'b0, 8'b0000_0000, 4'b0000, 2'b00, 1'b0};
        tbl[10] = '{8'b0000_1010, 1'b0, 8'b0000_0000, 4'b0000, 2'b00, 1'b0};
        tbl[11] = '{8'b0000_1010, 1'b0, 8'b0000_1010, 4'b0000, 2'b00, 1'b1};
        tbl[12] = '{8'b0000_0000, 1'b1, 8'b0000_1010, 4'b0000, 2'b00, 1'b0};
        tbl[13] = '{8'b0000_0000, 1'b0, 8'b0000_0000, 4'b0000, 2'b00, 1'b0};
        tbl[14] = '{8'b0000_1100, 1'b0, 8'b0000_0000, 4'b0000, 2'b00, 1'b0};
        tbl[15] = '{8'b0000_1100, 1'b0, 8'b0000_1100, 4'b0000, 2'b00, 1'b0};
        tbl[16] = '{8'b0000_1110, 1'b0, 8'b0000_1100, 4'b0000, 2'b00, 1'b0};
        tbl[17] = '{8'b0000_1110, 1'b0, 8'b0000_1110, 4'b0000, 2'b10, 1'b1};
        tbl[18] = '{8'b0000_0000, 1'b0, 8'b0000_1110, 4'b0000, 2'b10, 1'b1};
        tbl[19] = '{8'b0000_0000, 1'b0, 8'b0000_0000, 4'b0000, 2'b10, 1'b1};
        tbl[20] = '{8'b0000_0001, 1'b0, 8'b0000_0000, 4'b0000, 2'b10, 1'b1};
        tbl[21] = '{8'b0000_0001, 1'b0, 8'b0000_0001, 4'b0000, 2'b11, 1'b1};
        tbl[22] = '{8'b0000_0101, 1'b0, 8'b0000_0001, 4'b0000, 2'b11, 1'b1};
        tbl[23] = '{8'b0000_0101, 1'b1, 8'b0000_0101, 4'b0000, 2'b01, 1'b1};
        tbl[24] = '{8'b1100_0101, 1'b0, 8'b0000_0101, 4'b0000, 2'b01, 1'b1};
        tbl[25] = '{8'b1100_0101, 1'b0, 8'b1100_0101, 4'b1100, 2'b01, 1'b1};
        tbl[26] = '{8'b0010_0101, 1'b0, 8'b1100_0101, 4'b0000, 2'b01, 1'b1};
        tbl[27] = '{8'b0010_0101, 1'b0, 8'b0010_0101, 4'b0010, 2'b01, 1'b1};

        #1;
        check("reset_outputs", 32'({start_out, buttons_stable, presses(), dir, dir_valid}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_rise(PP, "first_rise");

        for (int i = 0; i < 28; i++) poll(tbl[i].b, 1'b0, tbl[i].ack, 1'b1, tbl[i]);

        // ack with nothing loading: valid drops, dir keeps 01
        poll(8'b0010_0101, 1'b1, 1'b0, 1'b0, dummy);
        check("dir_kept_after_ack", 32'(dir), 32'd1);

        // reset during WAIT with Up held; the abandoned sample must not count
        buttons_pressed = 8'b0000_1000;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", 32'({start_out, buttons_stable, presses(), dir, dir_valid}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_rise(PP, "rise_after_reset");
        poll(8'b0000_1000, 1'b0, 1'b0, 1'b0, dummy);
        poll(8'b0000_1000, 1'b0, 1'b0, 1'b0, dummy);

        rb = '0;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) rb = 8'($urandom);
            am = ($urandom_range(0, 3) == 0);
            as = ($urandom_range(0, 3) == 0);
            poll(rb, am, as, 1'b0, dummy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
